// File: rtl/cjb_mem_arbiter.sv
// Two-master arbiter/sequencer for the single-port data RAM; CJB_ARB_ROUND_ROBIN_EN selects round-robin ties.
// Latency: ack 2 cycles after request sample for writes, 2+READ_LAT for reads.
// Backpressure: one transaction in flight; requests stay pending (level) until their ack.
module cjb_mem_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 16,
    parameter int READ_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic [1:0]    grant,
    output logic          busy,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    localparam logic [1:0] LAT_INIT = 2'(READ_LAT - 1);

    state_t        state;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [1:0]    cnt;
    logic          pick1;

`ifdef CJB_ARB_ROUND_ROBIN_EN
    logic          last_grant;

    always_comb begin
        pick1 = 1'b0;
        if (req0 && req1)
            pick1 = !last_grant;
        else
            pick1 = req1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= 1'b1;
        else if (state == DONE)
            last_grant <= grant[1];
    end
`else
    always_comb begin
        pick1 = 1'b0;
        pick1 = req1 && !req0;
    end
`endif

    // RAM port is a pure decode of state and latches; idle values are forced to zero.
    assign mem_en    = (state == ACCESS);
    assign mem_we    = mem_en & lat_we;
    assign mem_addr  = mem_en ? lat_addr  : '0;
    assign mem_wdata = mem_en ? lat_wdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            cnt       <= 2'd0;
            grant     <= 2'b00;
            busy      <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        lat_we    <= pick1 ? we1    : we0;
                        lat_addr  <= pick1 ? addr1  : addr0;
                        lat_wdata <= pick1 ? wdata1 : wdata0;
                        grant     <= pick1 ? 2'b10  : 2'b01;
                        busy      <= 1'b1;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (lat_we) begin
                        ack0  <= grant[0];
                        ack1  <= grant[1];
                        state <= DONE;
                    end else begin
                        cnt   <= LAT_INIT;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 2'd0) begin
                        cnt <= cnt - 2'd1;
                    end else begin
                        rdata <= mem_rdata;
                        ack0  <= grant[0];
                        ack1  <= grant[1];
                        state <= DONE;
                    end
                end
                DONE: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    grant <= 2'b00;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cjb_mem_arbiter.sv
// Bench for cjb_mem_arbiter: vector table plus hand sequences, acks checked against a scoreboard queue.
module tb_cjb_mem_arbiter;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int RL = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, busy, mem_en, mem_we;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic [1:0]    grant;
    logic [AW-1:0] mem_addr;

    cjb_mem_arbiter #(.AW(AW), .DW(DW), .READ_LAT(RL)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .grant(grant), .busy(busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model with RL-cycle read pipeline; non-read cycles push a marker value.
    logic [DW-1:0] ram [0:255];
    logic [DW-1:0] rpipe [RL];
    initial for (int i = 0; i < 256; i++) ram[i] = '0;
    initial for (int i = 0; i < RL; i++) rpipe[i] = '0;
    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        rpipe[0] <= (mem_en && !mem_we) ? ram[mem_addr] : 16'hDEAD;
        for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata = rpipe[RL-1];

    typedef struct {
        logic          m;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          drop;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic [1:0]    onehot;
        logic          chk_rd;
        logic [DW-1:0] rd;
        int            cyc;
    } sb_t;

    sb_t sb[$];
    sb_t e_mon;
    int  n_vec = 0;
    int  n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (!mem_en)
                chk("mem_idle_zero", {7'd0, mem_we, mem_addr, mem_wdata}, 32'd0);
            if (ack0 || ack1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
                end else begin
                    e_mon = sb.pop_front();
                    chk("ack_who", {30'd0, ack1, ack0}, {30'd0, e_mon.onehot});
                    chk("ack_cycle", cyc, e_mon.cyc);
                    chk("ack_grant", {30'd0, grant}, {30'd0, e_mon.onehot});
                    if (e_mon.chk_rd) chk("rdata", {16'd0, rdata}, {16'd0, e_mon.rd});
                end
            end
        end
    end

    task automatic drive(input logic m, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (m) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
        else   begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    endtask

    task automatic push(input logic [1:0] oh, input logic crd, input logic [DW-1:0] rd, input int c);
        sb_t e;
        e.onehot = oh; e.chk_rd = crd; e.rd = rd; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic idle_check(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_grant"}, {30'd0, grant}, 32'd0);
        if (sb.size() != 0) begin
            chk({tag, "_missing_ack"}, sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    task automatic run_txn(input vec_t v);
        int c0;
        int lat;
        @(negedge clk);
        c0  = cyc;
        lat = v.we ? 2 : 2 + RL;
        drive(v.m, v.we, v.addr, v.wdata);
        push(v.m ? 2'b10 : 2'b01, !v.we, v.exp_rdata, c0 + lat);
        @(negedge clk);
        chk("c1_mem_en", {31'd0, mem_en}, 32'd1);
        chk("c1_mem_we", {31'd0, mem_we}, {31'd0, v.we});
        chk("c1_mem_addr", {24'd0, mem_addr}, {24'd0, v.addr});
        chk("c1_mem_wdata", {16'd0, mem_wdata}, {16'd0, v.wdata});
        chk("c1_busy", {31'd0, busy}, 32'd1);
        if (v.drop) begin req0 = 1'b0; req1 = 1'b0; end
        while (cyc < c0 + lat) @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        idle_check("post_txn");
    endtask

    vec_t tbl [10];
    int   c0;
    logic [1:0] tie_exp [4];

    initial begin
        tbl[0] = '{1'b0, 1'b1, 8'h10, 16'h1234, 1'b0, 16'h0000};
        tbl[1] = '{1'b1, 1'b0, 8'h10, 16'h5555, 1'b0, 16'h1234};
        tbl[2] = '{1'b1, 1'b1, 8'h20, 16'hBEEF, 1'b0, 16'h0000};
        tbl[3] = '{1'b0, 1'b0, 8'h20, 16'h0000, 1'b0, 16'hBEEF};
        tbl[4] = '{1'b0, 1'b1, 8'hFF, 16'hFFFF, 1'b0, 16'h0000};
        tbl[5] = '{1'b1, 1'b0, 8'hFF, 16'h0001, 1'b0, 16'hFFFF};
        tbl[6] = '{1'b0, 1'b1, 8'h00, 16'h0000, 1'b0, 16'h0000};
        tbl[7] = '{1'b1, 1'b0, 8'h00, 16'hAAAA, 1'b0, 16'h0000};
        tbl[8] = '{1'b0, 1'b1, 8'h33, 16'hA5A5, 1'b1, 16'h0000};
        tbl[9] = '{1'b0, 1'b0, 8'h33, 16'h0000, 1'b0, 16'hA5A5};
`ifdef CJB_ARB_ROUND_ROBIN_EN
        tie_exp[0] = 2'b01; tie_exp[1] = 2'b10; tie_exp[2] = 2'b01; tie_exp[3] = 2'b10;
`else
        tie_exp[0] = 2'b01; tie_exp[1] = 2'b01; tie_exp[2] = 2'b01; tie_exp[3] = 2'b01;
`endif

        #1;
        chk("rst_outs", {ack0, ack1, grant, busy, mem_en, mem_we, 25'd0},  32'd0);
        chk("rst_rdata", {16'd0, rdata}, 32'd0);
        chk("rst_mem_bus", {8'd0, mem_addr, mem_wdata}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_txn(tbl[i]);

        // Both masters hold write requests across four transactions.
        @(negedge clk);
        c0 = cyc;
        drive(1'b0, 1'b1, 8'h40, 16'h0040);
        drive(1'b1, 1'b1, 8'h41, 16'h0041);
        for (int k = 0; k < 4; k++) push(tie_exp[k], 1'b0, 16'h0, c0 + 2 + 3 * k);
        while (cyc < c0 + 11) @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        idle_check("tie");

        // Master 1 holds req across its ack: second mem_en exactly 3 cycles after the first.
        @(negedge clk);
        c0 = cyc;
        drive(1'b1, 1'b1, 8'h50, 16'h0050);
        push(2'b10, 1'b0, 16'h0, c0 + 2);
        push(2'b10, 1'b0, 16'h0, c0 + 5);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("b2b_mem_en", {31'd0, mem_en}, (k == 1 || k == 4) ? 32'd1 : 32'd0);
        end
        req1 = 1'b0;
        @(negedge clk);
        idle_check("b2b");

        // Reset pulled during WAIT of a read.
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h10, 16'h0000);
        repeat (2) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_grant", {30'd0, grant}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("mid_rst_ack", {30'd0, ack1, ack0}, 32'd0);
        req0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        run_txn('{1'b0, 1'b0, 8'h10, 16'h0000, 1'b0, 16'h1234});

        if (sb.size() != 0) chk("final_sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        n_bad++;
        $display("FAIL timeout: got no finish expected finish before 500000");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "timeout");
    end

endmodule
